// File: rtl/gmem_responder.sv
// Vector global-memory responder: one LANES-wide load/store per cycle, fixed-latency
// pipeline into a credit-protected response FIFO, strictly in-order responses.
module gmem_responder #(
    parameter int LANES     = 4,
    parameter int ADDR_W    = 8,
    parameter int TAG_W     = 4,
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LANES-1:0]      req_mask,
    input  logic [32*LANES-1:0]   req_wdata,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [32*LANES-1:0]   rsp_rdata,
    output logic [TAG_W-1:0]      rsp_tag
);
    localparam int DW    = 32 * LANES;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NSTG  = (LAT > 1) ? LAT - 1 : 1;
    localparam int PW    = $clog2(RSP_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(RSP_DEPTH);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [CW-1:0]    outstanding_r;
    logic             accept_s;
    logic             pop_s;
    logic [DW-1:0]    old_s;
    logic [DW-1:0]    merged_s;
    logic [DW-1:0]    acc_data_s;

    logic             stg_vld_r  [NSTG];
    logic             stg_we_r   [NSTG];
    logic [DW-1:0]    stg_data_r [NSTG];
    logic [TAG_W-1:0] stg_tag_r  [NSTG];

    logic             push_s;
    logic             push_we_s;
    logic [DW-1:0]    push_data_s;
    logic [TAG_W-1:0] push_tag_s;

    logic             fifo_we_r   [RSP_DEPTH];
    logic [DW-1:0]    fifo_data_r [RSP_DEPTH];
    logic [TAG_W-1:0] fifo_tag_r  [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    fifo_cnt_r;

    // Credits bound in-flight + queued responses, so the FIFO can never overflow.
    assign req_ready = reset_n & (outstanding_r < MAX_OUT);
    assign accept_s  = req_valid & req_ready;
    assign pop_s     = rsp_valid & rsp_ready;

    // Lane-masked merge of store data over the current word; loads return the old word.
    always_comb begin
        old_s    = mem_r[req_addr];
        merged_s = old_s;
        for (int i = 0; i < LANES; i++) begin
            if (req_mask[i]) begin
                merged_s[32*i +: 32] = req_wdata[32*i +: 32];
            end else begin
                merged_s[32*i +: 32] = old_s[32*i +: 32];
            end
        end
        if (req_we) begin
            acc_data_s = merged_s;
        end else begin
            acc_data_s = old_s;
        end
    end

    // Memory array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && req_we) begin
            mem_r[req_addr] <= merged_s;
        end
    end

    // Outstanding credit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Fixed-latency delay line between accept and FIFO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTG; k++) begin
                stg_vld_r[k]  <= 1'b0;
                stg_we_r[k]   <= 1'b0;
                stg_data_r[k] <= {DW{1'b0}};
                stg_tag_r[k]  <= {TAG_W{1'b0}};
            end
        end else begin
            stg_vld_r[0]  <= accept_s;
            stg_we_r[0]   <= req_we;
            stg_data_r[0] <= acc_data_s;
            stg_tag_r[0]  <= req_tag;
            for (int k = 1; k < NSTG; k++) begin
                stg_vld_r[k]  <= stg_vld_r[k-1];
                stg_we_r[k]   <= stg_we_r[k-1];
                stg_data_r[k] <= stg_data_r[k-1];
                stg_tag_r[k]  <= stg_tag_r[k-1];
            end
        end
    end

    // With LAT==1 the accepted request goes straight into the FIFO.
    always_comb begin
        if (LAT == 1) begin
            push_s      = accept_s;
            push_we_s   = req_we;
            push_data_s = acc_data_s;
            push_tag_s  = req_tag;
        end else begin
            push_s      = stg_vld_r[NSTG-1];
            push_we_s   = stg_we_r[NSTG-1];
            push_data_s = stg_data_r[NSTG-1];
            push_tag_s  = stg_tag_r[NSTG-1];
        end
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < RSP_DEPTH; k++) begin
                fifo_we_r[k]   <= 1'b0;
                fifo_data_r[k] <= {DW{1'b0}};
                fifo_tag_r[k]  <= {TAG_W{1'b0}};
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_we_r[wr_ptr_r]   <= push_we_s;
                fifo_data_r[wr_ptr_r] <= push_data_s;
                fifo_tag_r[wr_ptr_r]  <= push_tag_s;
                wr_ptr_r              <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1'b1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1'b1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt_r != {CW{1'b0}});
    assign rsp_we    = fifo_we_r[rd_ptr_r];
    assign rsp_rdata = fifo_data_r[rd_ptr_r];
    assign rsp_tag   = fifo_tag_r[rd_ptr_r];

endmodule

// File: tb/tb_gmem_responder.sv
// Scoreboard bench for gmem_responder: a driver updates a word-level memory model and
// queues expected responses; an independent monitor checks timing, order and content.
module tb_gmem_responder;
    localparam int LANES     = 4;
    localparam int ADDR_W    = 8;
    localparam int TAG_W     = 4;
    localparam int LAT       = 2;
    localparam int RSP_DEPTH = 4;
    localparam int DW        = 32 * LANES;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_mask;
    logic [DW-1:0]     req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DW-1:0]     rsp_rdata;
    logic [TAG_W-1:0]  rsp_tag;

    gmem_responder #(
        .LANES(LANES), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             we;
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        int               avail;
    } exp_t;

    exp_t          sb[$];
    logic [31:0]   mem_m [1<<ADDR_W][LANES];
    int            cyc = 0;
    int            last_pop = -1;
    int            vectors = 0;
    int            miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples well after the falling edge, independent of the driver.
    exp_t mon_e;
    logic mon_ev;
    int   mon_h;
    always @(negedge clk) begin
        #2;
        mon_ev = 1'b0;
        if (sb.size() > 0) begin
            mon_h  = (sb[0].avail > last_pop + 1) ? sb[0].avail : last_pop + 1;
            mon_ev = (mon_h <= cyc);
        end
        check("rsp_valid_timing", {{(DW-1){1'b0}}, rsp_valid}, {{(DW-1){1'b0}}, mon_ev});
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("rsp_we", {{(DW-1){1'b0}}, rsp_we}, {{(DW-1){1'b0}}, mon_e.we});
            check("rsp_tag", {{(DW-TAG_W){1'b0}}, rsp_tag}, {{(DW-TAG_W){1'b0}}, mon_e.tag});
            check("rsp_rdata", rsp_rdata, mon_e.data);
            last_pop = cyc;
        end
    end

    function automatic logic [DW-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < LANES; i++) w[32*i +: 32] = mem_m[a][i];
        return w;
    endfunction

    // Reference: a store overwrites the enabled lanes, every response carries the word.
    task automatic model_accept(input logic we, input logic [ADDR_W-1:0] a,
                                input logic [LANES-1:0] m, input logic [DW-1:0] wd,
                                input logic [TAG_W-1:0] t);
        exp_t e;
        if (we) begin
            for (int i = 0; i < LANES; i++)
                if (m[i]) mem_m[a][i] = wd[32*i +: 32];
        end
        e.we    = we;
        e.data  = word_of(a);
        e.tag   = t;
        e.avail = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [LANES-1:0] m, input logic [DW-1:0] wd,
                         input logic [TAG_W-1:0] t, output logic acc);
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_mask = m; req_wdata = wd; req_tag = t;
        #1;
        acc = v && req_ready;
        if (acc) model_accept(we, a, m, wd, t);
    endtask

    task automatic idle();
        logic acc;
        drive(1'b0, 1'b0, {ADDR_W{1'b0}}, {LANES{1'b0}}, {DW{1'b0}}, {TAG_W{1'b0}}, acc);
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m,
                         input logic [DW-1:0] wd, input logic [TAG_W-1:0] t);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            drive(1'b1, we, a, m, wd, t, acc);
            tries++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected one", tries);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic acc;
        int   next_tag;
        reset_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0; req_tag = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", {{(DW-1){1'b0}}, req_ready}, {DW{1'b0}});
        check("reset_rsp_valid", {{(DW-1){1'b0}}, rsp_valid}, {DW{1'b0}});
        check("reset_rsp_we", {{(DW-1){1'b0}}, rsp_we}, {DW{1'b0}});
        check("reset_rsp_rdata", rsp_rdata, {DW{1'b0}});
        check("reset_rsp_tag", {{(DW-TAG_W){1'b0}}, rsp_tag}, {DW{1'b0}});
        reset_n = 1'b1;
        #1;
        check("release_req_ready", {{(DW-1){1'b0}}, req_ready}, {{(DW-1){1'b0}}, 1'b1});

        // Fill every word so all later loads are defined.
        for (int a = 0; a < (1 << ADDR_W); a++)
            issue(1'b1, ADDR_W'(a), 4'b1111, rnd_word(), TAG_W'(a));

        // Full store then load of the same word.
        issue(1'b1, 8'd9, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd1);
        issue(1'b0, 8'd9, 4'b0000, {DW{1'b0}}, 4'd2);

        // Partial-lane store.
        issue(1'b1, 8'd5, 4'b1111, {32'hD, 32'hC, 32'hB, 32'hA}, 4'd3);
        issue(1'b1, 8'd5, 4'b0101, {32'hFF, 32'hEE, 32'hDD, 32'hCC}, 4'd4);
        issue(1'b0, 8'd5, 4'b0000, {DW{1'b0}}, 4'd5);
        issue(1'b1, 8'd5, 4'b0000, rnd_word(), 4'd6);

        // Store followed immediately by a load of the same address.
        issue(1'b1, 8'd3, 4'b1111, rnd_word(), 4'd7);
        issue(1'b0, 8'd3, 4'b0000, {DW{1'b0}}, 4'd8);
        idle();
        wait_drain();

        // Backpressure: only RSP_DEPTH loads may be outstanding.
        rsp_ready = 1'b0;
        next_tag = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, ADDR_W'($urandom), 4'b0000, {DW{1'b0}}, TAG_W'(next_tag), acc);
            if (acc) next_tag++;
        end
        check("bp_accepted", DW'(next_tag), DW'(RSP_DEPTH));
        check("bp_req_ready", {{(DW-1){1'b0}}, req_ready}, {DW{1'b0}});
        rsp_ready = 1'b1;
        while (next_tag < 8) begin
            issue(1'b0, ADDR_W'($urandom), 4'b0000, {DW{1'b0}}, TAG_W'(next_tag));
            next_tag++;
        end
        idle();
        wait_drain();

        // Sustained throughput with rsp_ready held high.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'($urandom), ADDR_W'($urandom_range(0, 7)), LANES'($urandom),
                  rnd_word(), TAG_W'(i), acc);
            check("b2b_accept", {{(DW-1){1'b0}}, acc}, {{(DW-1){1'b0}}, 1'b1});
        end
        idle();
        wait_drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
                  LANES'($urandom), rnd_word(), TAG_W'($urandom), acc);
        end
        rsp_ready = 1'b1;
        idle();
        wait_drain();

        // Reset with requests in flight; memory must survive.
        issue(1'b1, 8'h77, 4'b1111, rnd_word(), 4'd9);
        issue(1'b0, 8'h10, 4'b0000, {DW{1'b0}}, 4'd10);
        issue(1'b0, 8'h11, 4'b0000, {DW{1'b0}}, 4'd11);
        issue(1'b0, 8'h12, 4'b0000, {DW{1'b0}}, 4'd12);
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_rsp_valid", {{(DW-1){1'b0}}, rsp_valid}, {DW{1'b0}});
        check("midreset_req_ready", {{(DW-1){1'b0}}, req_ready}, {DW{1'b0}});
        @(negedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        check("postreset_req_ready", {{(DW-1){1'b0}}, req_ready}, {{(DW-1){1'b0}}, 1'b1});
        issue(1'b0, 8'h77, 4'b0000, {DW{1'b0}}, 4'd13);
        issue(1'b0, 8'd9, 4'b0000, {DW{1'b0}}, 4'd14);
        idle();
        wait_drain();
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
